// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Request/response bundle between the control unit and the sequential
//   divider.
//   start       : request, honoured only while busy is low
//   signed_op   : 1 = two's-complement divide, 0 = unsigned
//   dividend    : numerator, captured together with start
//   divisor     : denominator, captured together with start
//   busy        : an operation is in progress
//   done        : one-cycle pulse, quotient/remainder valid
//   div_by_zero : qualifies done, divisor was zero
//   quotient    : result destined for LO
//   remainder   : result destined for HI
//   The master modport is the requester (control unit or bench).
//   The slave modport is the divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle restoring divider. It produces one quotient bit per clock and
//   serves the DIV instruction: the quotient goes to LO and the remainder to HI.
//   Ports:
//     clk   : system clock, all state changes on the rising edge
//     rst_n : synchronous active-low reset, aborts any operation in flight
//     bus   : seq_divider_if.slave, carrying the start/busy/done handshake,
//             the operands and the results
//   Signed operands are divided as magnitudes and the signs are applied in a
//   final fixup cycle. The quotient truncates toward zero and the remainder
//   follows the dividend's sign. A zero divisor skips the iteration and returns
//   an all-ones quotient, with the raw dividend as the remainder.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FIXUP  = 2'd2;

  // Magnitude of an operand. -2^(WIDTH-1) maps onto itself, and that value
  // reads correctly as an unsigned 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_neg);
    logic [WIDTH-1:0] m;
    if (is_neg) begin
      m = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] rem_q,       rem_d;        // working partial remainder
  logic [WIDTH-1:0] quo_q,       quo_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvsr_q,      dvsr_d;       // divisor magnitude
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             q_neg_q,     q_neg_d;
  logic             r_neg_q,     r_neg_d;
  logic             dz_pend_q,   dz_pend_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             dz_q,        dz_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             a_neg_s;
  logic             b_neg_s;

  // Next-state and datapath logic for the whole divider.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_pend_d   = dz_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    a_neg_s   = bus.signed_op & bus.dividend[WIDTH-1];
    b_neg_s   = bus.signed_op & bus.divisor[WIDTH-1];
    // Shift {R,Q} left by one. The trial subtraction is WIDTH+1 bits wide,
    // and its top bit is the borrow (trial < 0).
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, dvsr_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          dz_d    = 1'b0;
          cnt_d   = CNT_INIT;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            // The working registers already hold the final result.
            // Fixup then only copies them out.
            rem_d     = bus.dividend;
            quo_d     = {WIDTH{1'b1}};
            dvsr_d    = {WIDTH{1'b0}};
            q_neg_d   = 1'b0;
            r_neg_d   = 1'b0;
            dz_pend_d = 1'b1;
            state_d   = S_FIXUP;
          end else begin
            rem_d     = {WIDTH{1'b0}};
            quo_d     = magnitude(bus.dividend, a_neg_s);
            dvsr_d    = magnitude(bus.divisor, b_neg_s);
            q_neg_d   = a_neg_s ^ b_neg_s;
            r_neg_d   = a_neg_s;
            dz_pend_d = 1'b0;
            state_d   = S_DIVIDE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DIVIDE: begin
        if (trial_s[WIDTH] == 1'b0) begin
          rem_d = trial_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIXUP;
        end else begin
          state_d = S_DIVIDE;
        end
      end

      S_FIXUP: begin
        quotient_d  = magnitude(quo_q, q_neg_q);
        remainder_d = magnitude(rem_q, r_neg_q);
        dz_d        = dz_pend_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvsr_q      <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_pend_q   <= dz_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed table of divides with hand-computed results.
//   Hand-written sequences cover:
//     - a start pulsed while busy
//     - reset during an operation
//     - back-to-back operations
//   A short run of random operands is checked against the language operators.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  seq_divider_if #(.WIDTH(32)) bus_if ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from the language operators.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // The caller must be at a negedge. The task returns at the negedge of the
  // done cycle. When inject is set, it pulses start with 1/1 at cycle 10.
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input logic inject);
    int lat;
    int busy_bad;
    int exp_lat;
    exp_lat = edz ? 2 : 34;
    bus_if.start     = 1'b1;
    bus_if.signed_op = s;
    bus_if.dividend  = a;
    bus_if.divisor   = b;
    @(negedge clk);
    bus_if.start     = 1'b0;
    bus_if.dividend  = $urandom;
    bus_if.divisor   = $urandom;
    bus_if.signed_op = ~s;
    lat      = 1;
    busy_bad = 0;
    while (!bus_if.done && lat < 100) begin
      if (!bus_if.busy) busy_bad++;
      if (inject && lat == 10) begin
        bus_if.start    = 1'b1;
        bus_if.dividend = 32'd1;
        bus_if.divisor  = 32'd1;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus_if.start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, " busy_in_done"}, {31'd0, bus_if.busy}, 32'd0);
    check({tag, " quotient"}, bus_if.quotient, eq);
    check({tag, " remainder"}, bus_if.remainder, er);
    check({tag, " div_by_zero"}, {31'd0, bus_if.div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rq, rr;
    logic        rs, rdz;
    int          seen;

    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0};
    vecs[7]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[8]  = '{1'b1, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'd0,          32'd7,          32'd0,          32'd0,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1};
    vecs[11] = '{1'b0, 32'd7,          32'd9,          32'd0,          32'd7,          1'b0};
    vecs[12] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};

    rst_n            = 1'b0;
    bus_if.start     = 1'b0;
    bus_if.signed_op = 1'b0;
    bus_if.dividend  = 32'd0;
    bus_if.divisor   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, bus_if.busy}, 32'd0);
    check("reset done", {31'd0, bus_if.done}, 32'd0);
    check("reset dz", {31'd0, bus_if.div_by_zero}, 32'd0);
    check("reset quotient", bus_if.quotient, 32'd0);
    check("reset remainder", bus_if.remainder, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), {31'd0, bus_if.done}, 32'd0);
    end

    // A start pulsed while busy must not disturb the running divide.
    run_op("busy_start", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
    @(negedge clk);

    // Reset part-way through an operation aborts it, and no done follows.
    bus_if.start     = 1'b1;
    bus_if.signed_op = 1'b0;
    bus_if.dividend  = 32'd77;
    bus_if.divisor   = 32'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", {31'd0, bus_if.busy}, 32'd0);
    check("abort done", {31'd0, bus_if.done}, 32'd0);
    check("abort quotient", bus_if.quotient, 32'd0);
    check("abort remainder", bus_if.remainder, 32'd0);
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus_if.done) seen++;
    end
    check("abort no_done", 32'(seen), 32'd0);

    // Back-to-back: the second start is in the first done cycle.
    run_op("b2b_first", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op("b2b_second", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
    run_op("b2b_third", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
    @(negedge clk);

    // Random operands against the reference operators.
    for (int k = 0; k < 200; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 20));
        1:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      model(rs, ra, rb, rq, rr, rdz);
      run_op($sformatf("rand%0d", k), rs, ra, rb, rq, rr, rdz, 1'b0);
    end
    @(negedge clk);
    check("final done_pulse", {31'd0, bus_if.done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
